bcd_convert_arbiter: RTL

Shares one iterative binary-to-BCD converter between several score or timer channels of the answering machine. Each channel asks for a conversion, and a round-robin arbiter grants it. The granted 8-bit operand is converted by 8 serial shift/add-3 steps into a 3-digit packed BCD result (0–255). The result goes to the display/segment driver stage together with the ID of the channel it belongs to.

---
 rtl/bcd_convert_arbiter.sv | 118 +++++++++++
 1 files changed

// File: rtl/bcd_convert_arbiter.sv
// Round-robin arbitrated binary-to-BCD converter: one 8-bit operand per grant,
// converted by 8 serial shift/add-3 steps into a packed 3-digit BCD result.
module bcd_convert_arbiter #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned ID_W  = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_REQ-1:0]   req,
   input  logic [8*N_REQ-1:0] bin_data,
   output logic [N_REQ-1:0]   grant,
   output logic               busy,
   output logic               done,
   output logic [ID_W-1:0]    done_id,
   output logic [11:0]        bcd_out
);

   localparam int unsigned CNT_W = 4;
   localparam int unsigned STEPS = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t             state;
   logic [ID_W-1:0]    ptr;
   logic [ID_W-1:0]    cur_id;
   logic [CNT_W-1:0]   cnt;
   logic [7:0]         shreg;
   logic [11:0]        acc;

   logic               any_req;
   logic [ID_W-1:0]    win_id;
   logic [11:0]        acc_corr;
   logic [11:0]        acc_next;
   logic [7:0]         shreg_next;

   // Winner is the first set req at or above ptr, wrapping; scan from the far end so the nearest wins.
   always_comb begin
      any_req = 1'b0;
      win_id  = '0;
      for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
         int idx;
         idx = (int'(ptr) + k) % int'(N_REQ);
         if (req[idx]) begin
            any_req = 1'b1;
            win_id  = ID_W'(idx);
         end
      end
   end

   // One double-dabble step: correct every nibble from pre-step values, then shift.
   always_comb begin
      acc_corr = acc;
      for (int n = 0; n < 3; n++) begin
         if (acc[4*n +: 4] >= 4'd5) begin
            acc_corr[4*n +: 4] = acc[4*n +: 4] + 4'd3;
         end
      end
      acc_next   = {acc_corr[10:0], shreg[7]};
      shreg_next = {shreg[6:0], 1'b0};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         ptr     <= '0;
         cur_id  <= '0;
         cnt     <= '0;
         shreg   <= '0;
         acc     <= '0;
         grant   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         done_id <= '0;
         bcd_out <= '0;
      end else begin
         grant <= '0;
         done  <= 1'b0;
         case (state)
            IDLE: begin
               if (any_req) begin
                  shreg  <= bin_data[8*win_id +: 8];
                  acc    <= '0;
                  cnt    <= '0;
                  cur_id <= win_id;
                  grant  <= N_REQ'(1) << win_id;
                  busy   <= 1'b1;
                  state  <= SHIFT;
               end
            end
            SHIFT: begin
               acc   <= acc_next;
               shreg <= shreg_next;
               cnt   <= cnt + CNT_W'(1);
               if (cnt == CNT_W'(STEPS - 1)) begin
                  bcd_out <= acc_next;
                  done_id <= cur_id;
                  done    <= 1'b1;
                  state   <= DONE;
               end
            end
            DONE: begin
               ptr   <= (cur_id == ID_W'(N_REQ - 1)) ? '0 : cur_id + ID_W'(1);
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
